// File: rtl/hdmi_timing_generator.sv
// Runtime-programmable HDMI timing generator: pixel counters, sync pulses and
// per-pixel HDMI period classification. Timing lives in shadow registers that
// are only swapped on the last pixel of a frame, so a new format starts cleanly.
module hdmi_timing_generator #(
    parameter int BIT_WIDTH   = 12,
    parameter int BIT_HEIGHT  = 11,
    parameter int MAX_PACKETS = 18,
    parameter bit DVI_OUTPUT  = 1'b0
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [BIT_WIDTH-1:0]  cfg_frame_width,
    input  logic [BIT_HEIGHT-1:0] cfg_frame_height,
    input  logic [BIT_WIDTH-1:0]  cfg_screen_width,
    input  logic [BIT_HEIGHT-1:0] cfg_screen_height,
    input  logic [BIT_WIDTH-1:0]  cfg_hsync_start,
    input  logic [BIT_WIDTH-1:0]  cfg_hsync_len,
    input  logic [BIT_HEIGHT-1:0] cfg_vsync_start,
    input  logic [BIT_HEIGHT-1:0] cfg_vsync_len,
    input  logic                  cfg_hsync_pol,
    input  logic                  cfg_vsync_pol,
    input  logic                  cfg_update,
    output logic                  cfg_pending,
    output logic                  cfg_error,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  hsync,
    output logic                  vsync,
    output logic [2:0]            mode,
    output logic                  video_preamble,
    output logic                  data_island_preamble,
    output logic [4:0]            num_packets,
    output logic                  frame_start
);

    // One extra bit so window edges such as ssx+32N+2 never wrap.
    localparam int WX = BIT_WIDTH + 1;
    localparam int WY = BIT_HEIGHT + 1;

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_ISLAND = 3'd3;
    localparam logic [2:0] MODE_IGUARD = 3'd4;

    // Packets per data island line: min(MAX_PACKETS, (screen_width-2)/32).
    function automatic logic [4:0] calc_packets(input logic [BIT_WIDTH-1:0] sw);
        logic [BIT_WIDTH-1:0] q;
        q = (sw - BIT_WIDTH'(2)) >> 5;
        if (DVI_OUTPUT || (sw < BIT_WIDTH'(2))) return 5'd0;
        if (q > BIT_WIDTH'(MAX_PACKETS)) return 5'(MAX_PACKETS);
        return q[4:0];
    endfunction

    logic [BIT_WIDTH-1:0]  r_fw, r_sw, r_hs, r_hl;
    logic [BIT_HEIGHT-1:0] r_fh, r_sh, r_vs, r_vl;
    logic                  r_hp, r_vp;
    logic [4:0]            r_num;
    logic                  r_pending, r_error;
    logic [BIT_WIDTH-1:0]  r_cx;
    logic [BIT_HEIGHT-1:0] r_cy;
    logic [2:0]            r_mode;
    logic                  r_vpre, r_dpre, r_hsync, r_vsync, r_fs;

    logic                  w_last_x, w_last_y, w_load, w_cfg_valid;
    logic [WX-1:0]         w_cx, w_ssx, w_di_end, w_hs_end;
    logic [BIT_HEIGHT-1:0] w_ssy;
    logic [WY-1:0]         w_vs_end;
    logic                  w_island, w_packets;
    logic                  w_lead_guard, w_trail_guard, w_pre_win;
    logic                  w_hs_act, w_vs_act, w_vpre, w_dpre;
    logic [2:0]            w_mode;

    assign w_last_x = (r_cx == r_fw - BIT_WIDTH'(1));
    assign w_last_y = (r_cy == r_fh - BIT_HEIGHT'(1));
    assign w_load   = w_last_x && w_last_y && (r_pending || cfg_update);

    // A format needs at least 10 blanking pixels (preamble + guard) and one blanking line.
    assign w_cfg_valid = (cfg_frame_width != '0) && (cfg_frame_height != '0)
                      && (({1'b0, cfg_screen_width} + WX'(10)) <= {1'b0, cfg_frame_width})
                      && (cfg_screen_height < cfg_frame_height);

    assign w_cx      = {1'b0, r_cx};
    assign w_ssx     = {1'b0, r_fw} - {1'b0, r_sw};
    assign w_ssy     = r_fh - r_sh;
    assign w_di_end  = w_ssx + WX'({r_num, 5'd0});
    assign w_hs_end  = {1'b0, r_hs} + {1'b0, r_hl};
    assign w_vs_end  = {1'b0, r_vs} + {1'b0, r_vl};
    assign w_island  = (r_cy < w_ssy);
    assign w_packets = (r_num != 5'd0);

    assign w_lead_guard  = ((w_cx + WX'(2)) >= w_ssx) && (w_cx < w_ssx);
    assign w_trail_guard = (w_cx >= w_di_end) && (w_cx < (w_di_end + WX'(2)));
    assign w_pre_win     = ((w_cx + WX'(10)) >= w_ssx) && ((w_cx + WX'(2)) < w_ssx);
    assign w_hs_act      = (w_cx >= {1'b0, r_hs}) && (w_cx < w_hs_end);
    assign w_vs_act      = ({1'b0, r_cy} >= {1'b0, r_vs}) && ({1'b0, r_cy} < w_vs_end);

    assign w_vpre = !DVI_OUTPUT && !w_island && w_pre_win;
    assign w_dpre = !DVI_OUTPUT && w_island && w_packets && w_pre_win;

    // Period classification of the current pixel, highest priority first.
    always_comb begin
        w_mode = MODE_CTRL;
        if (w_island) begin
            if (w_packets && (w_lead_guard || w_trail_guard))
                w_mode = MODE_IGUARD;
            else if ((w_cx >= w_ssx) && (w_cx < w_di_end))
                w_mode = MODE_ISLAND;
        end else begin
            if (!DVI_OUTPUT && w_lead_guard)
                w_mode = MODE_VGUARD;
            else if (w_cx >= w_ssx)
                w_mode = MODE_VIDEO;
        end
    end

    // Shadow timing registers and the pending/error handshake.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_fw      <= cfg_frame_width;
            r_fh      <= cfg_frame_height;
            r_sw      <= cfg_screen_width;
            r_sh      <= cfg_screen_height;
            r_hs      <= cfg_hsync_start;
            r_hl      <= cfg_hsync_len;
            r_vs      <= cfg_vsync_start;
            r_vl      <= cfg_vsync_len;
            r_hp      <= cfg_hsync_pol;
            r_vp      <= cfg_vsync_pol;
            r_num     <= calc_packets(cfg_screen_width);
            r_pending <= 1'b0;
            r_error   <= 1'b0;
        end else if (w_load) begin
            r_pending <= 1'b0;
            if (w_cfg_valid) begin
                r_fw    <= cfg_frame_width;
                r_fh    <= cfg_frame_height;
                r_sw    <= cfg_screen_width;
                r_sh    <= cfg_screen_height;
                r_hs    <= cfg_hsync_start;
                r_hl    <= cfg_hsync_len;
                r_vs    <= cfg_vsync_start;
                r_vl    <= cfg_vsync_len;
                r_hp    <= cfg_hsync_pol;
                r_vp    <= cfg_vsync_pol;
                r_num   <= calc_packets(cfg_screen_width);
                r_error <= 1'b0;
            end else begin
                r_error <= 1'b1;
            end
        end else if (cfg_update) begin
            r_pending <= 1'b1;
        end
    end

    // Pixel position counters.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_last_x) begin
            r_cx <= '0;
            r_cy <= w_last_y ? '0 : r_cy + BIT_HEIGHT'(1);
        end else begin
            r_cx <= r_cx + BIT_WIDTH'(1);
        end
    end

    // Registered classification, sync and frame marker, one cycle behind cx/cy.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_mode  <= MODE_CTRL;
            r_vpre  <= 1'b0;
            r_dpre  <= 1'b0;
            r_fs    <= 1'b0;
            r_hsync <= ~cfg_hsync_pol;
            r_vsync <= ~cfg_vsync_pol;
        end else begin
            r_mode  <= w_mode;
            r_vpre  <= w_vpre;
            r_dpre  <= w_dpre;
            r_fs    <= (r_cx == '0) && (r_cy == '0);
            r_hsync <= w_hs_act ? r_hp : ~r_hp;
            r_vsync <= w_vs_act ? r_vp : ~r_vp;
        end
    end

    assign cfg_pending          = r_pending;
    assign cfg_error            = r_error;
    assign cx                   = r_cx;
    assign cy                   = r_cy;
    assign hsync                = r_hsync;
    assign vsync                = r_vsync;
    assign mode                 = r_mode;
    assign video_preamble       = r_vpre;
    assign data_island_preamble = r_dpre;
    assign num_packets          = r_num;
    assign frame_start          = r_fs;

endmodule

// File: tb/tb_hdmi_timing_generator.sv
// Bench for hdmi_timing_generator: an HDMI and a DVI instance share stimulus and
// are compared every cycle against a frame-position reference model.
module tb_hdmi_timing_generator;

    localparam int BW = 12;
    localparam int BH = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, upd;
    logic [BW-1:0] fw_i, sw_i, hs_i, hl_i;
    logic [BH-1:0] fh_i, sh_i, vs_i, vl_i;
    logic          hp_i, vp_i;

    logic          a_pend, a_err, a_hs, a_vs, a_vpre, a_dpre, a_fs;
    logic [BW-1:0] a_cx;
    logic [BH-1:0] a_cy;
    logic [2:0]    a_mode;
    logic [4:0]    a_np;

    logic          d_pend, d_err, d_hs, d_vs, d_vpre, d_dpre, d_fs;
    logic [BW-1:0] d_cx;
    logic [BH-1:0] d_cy;
    logic [2:0]    d_mode;
    logic [4:0]    d_np;

    hdmi_timing_generator #(.BIT_WIDTH(BW), .BIT_HEIGHT(BH), .MAX_PACKETS(18), .DVI_OUTPUT(1'b0)) u_dut (
        .clk_pixel(clk), .reset(rst),
        .cfg_frame_width(fw_i), .cfg_frame_height(fh_i),
        .cfg_screen_width(sw_i), .cfg_screen_height(sh_i),
        .cfg_hsync_start(hs_i), .cfg_hsync_len(hl_i),
        .cfg_vsync_start(vs_i), .cfg_vsync_len(vl_i),
        .cfg_hsync_pol(hp_i), .cfg_vsync_pol(vp_i), .cfg_update(upd),
        .cfg_pending(a_pend), .cfg_error(a_err), .cx(a_cx), .cy(a_cy),
        .hsync(a_hs), .vsync(a_vs), .mode(a_mode),
        .video_preamble(a_vpre), .data_island_preamble(a_dpre),
        .num_packets(a_np), .frame_start(a_fs)
    );

    hdmi_timing_generator #(.BIT_WIDTH(BW), .BIT_HEIGHT(BH), .MAX_PACKETS(18), .DVI_OUTPUT(1'b1)) u_dvi (
        .clk_pixel(clk), .reset(rst),
        .cfg_frame_width(fw_i), .cfg_frame_height(fh_i),
        .cfg_screen_width(sw_i), .cfg_screen_height(sh_i),
        .cfg_hsync_start(hs_i), .cfg_hsync_len(hl_i),
        .cfg_vsync_start(vs_i), .cfg_vsync_len(vl_i),
        .cfg_hsync_pol(hp_i), .cfg_vsync_pol(vp_i), .cfg_update(upd),
        .cfg_pending(d_pend), .cfg_error(d_err), .cx(d_cx), .cy(d_cy),
        .hsync(d_hs), .vsync(d_vs), .mode(d_mode),
        .video_preamble(d_vpre), .data_island_preamble(d_dpre),
        .num_packets(d_np), .frame_start(d_fs)
    );

    typedef struct {int fw; int fh; int sw; int sh; int hs; int hl; int vs; int vl; int hp; int vp;} cfg_t;
    typedef struct {int mode; int vpre; int dpre; int hs; int vs;} cls_t;

    // Reference state: k is the pixel index inside the current frame.
    cfg_t inc, act;
    int   k;
    bit   pend, err;
    cls_t ea, ed;
    int   efs;
    int   n_pass = 0;
    int   n_total = 0;
    int   fs_seen = 0;

    function automatic int packets(cfg_t c, int dvi);
        int n;
        if (dvi != 0) return 0;
        n = (c.sw - 2) / 32;
        if (n < 0) n = 0;
        if (n > 18) n = 18;
        return n;
    endfunction

    function automatic bit is_valid(cfg_t c);
        return (c.fw > 0) && (c.fh > 0) && (c.fw - c.sw >= 10) && (c.fh - c.sh >= 1);
    endfunction

    function automatic cls_t classify(cfg_t c, int pos, int dvi);
        cls_t r;
        int x, y, ssx, ssy, n, de;
        bit island;
        x = pos % c.fw;
        y = pos / c.fw;
        ssx = c.fw - c.sw;
        ssy = c.fh - c.sh;
        n = packets(c, dvi);
        de = ssx + 32 * n;
        island = (y < ssy);
        r.mode = 0;
        if (island && n > 0 && ((x >= ssx - 2 && x < ssx) || (x >= de && x < de + 2))) r.mode = 4;
        else if (island && x >= ssx && x < de) r.mode = 3;
        else if (!island && dvi == 0 && x >= ssx - 2 && x < ssx) r.mode = 2;
        else if (!island && x >= ssx) r.mode = 1;
        r.vpre = (dvi == 0 && !island && x >= ssx - 10 && x < ssx - 2) ? 1 : 0;
        r.dpre = (dvi == 0 && island && n > 0 && x >= ssx - 10 && x < ssx - 2) ? 1 : 0;
        r.hs = (x >= c.hs && x < c.hs + c.hl) ? c.hp : 1 - c.hp;
        r.vs = (y >= c.vs && y < c.vs + c.vl) ? c.vp : 1 - c.vp;
        return r;
    endfunction

    function automatic cfg_t rand_cfg(bit valid);
        cfg_t c;
        c.fw = int'($urandom_range(40, 100));
        c.fh = int'($urandom_range(3, 6));
        if (valid) begin
            c.sw = c.fw - int'($urandom_range(10, c.fw - 1));
            c.sh = c.fh - int'($urandom_range(1, c.fh));
        end else if ($urandom_range(0, 1) == 1) begin
            c.sw = c.fw - int'($urandom_range(0, 9));
            c.sh = c.fh - 1;
        end else begin
            c.sw = c.fw - 20;
            c.sh = c.fh;
        end
        c.hs = int'($urandom_range(0, c.fw - 1));
        c.hl = int'($urandom_range(1, c.fw / 2));
        c.vs = int'($urandom_range(0, c.fh - 1));
        c.vl = int'($urandom_range(1, c.fh));
        c.hp = int'($urandom_range(0, 1));
        c.vp = int'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic set_cfg(input cfg_t c);
        inc  = c;
        fw_i = BW'(c.fw);  fh_i = BH'(c.fh);
        sw_i = BW'(c.sw);  sh_i = BH'(c.sh);
        hs_i = BW'(c.hs);  hl_i = BW'(c.hl);
        vs_i = BH'(c.vs);  vl_i = BH'(c.vl);
        hp_i = c.hp[0];    vp_i = c.vp[0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, obs, exp);
    endtask

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        if (rst) begin
            act = inc; k = 0; pend = 0; err = 0; efs = 0;
            ea = '{mode: 0, vpre: 0, dpre: 0, hs: 1 - inc.hp, vs: 1 - inc.vp};
            ed = ea;
        end else begin
            ea  = classify(act, k, 0);
            ed  = classify(act, k, 1);
            efs = (k == 0) ? 1 : 0;
            if (k == act.fw * act.fh - 1) begin
                if (pend || upd) begin
                    if (is_valid(inc)) begin act = inc; err = 0; end
                    else err = 1;
                    pend = 0;
                end
                k = 0;
            end else begin
                if (upd) pend = 1;
                k++;
            end
        end
    endtask

    task automatic check_all();
        chk("cx", a_cx, k % act.fw);
        chk("cy", a_cy, k / act.fw);
        chk("mode", a_mode, ea.mode);
        chk("video_preamble", a_vpre, ea.vpre);
        chk("island_preamble", a_dpre, ea.dpre);
        chk("hsync", a_hs, ea.hs);
        chk("vsync", a_vs, ea.vs);
        chk("frame_start", a_fs, efs);
        chk("num_packets", a_np, packets(act, 0));
        chk("cfg_pending", a_pend, pend);
        chk("cfg_error", a_err, err);
        chk("dvi_cx", d_cx, k % act.fw);
        chk("dvi_mode", d_mode, ed.mode);
        chk("dvi_video_preamble", d_vpre, ed.vpre);
        chk("dvi_island_preamble", d_dpre, ed.dpre);
        chk("dvi_num_packets", d_np, packets(act, 1));
        if (a_fs === 1'b1) fs_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        cfg_t c640, c720, bad, r;
        int   f0, rem;
        c640 = '{fw: 800, fh: 8, sw: 640, sh: 5, hs: 16, hl: 96, vs: 0, vl: 2, hp: 0, vp: 0};
        c720 = '{fw: 1650, fh: 6, sw: 1280, sh: 4, hs: 110, hl: 40, vs: 1, vl: 2, hp: 1, vp: 1};
        rst = 1'b1;
        upd = 1'b0;
        set_cfg(c640);

        // Reset with a 640-wide format, then two whole frames.
        repeat (3) cycle();
        rst = 1'b0;
        chk("np_640", a_np, 18);
        f0 = fs_seen;
        repeat (2 * 800 * 8) cycle();
        chk("frame_start_per_2_frames", fs_seen - f0, 2);

        // Mid-frame switch to a 1650-wide format.
        repeat (3000) cycle();
        set_cfg(c720);
        upd = 1'b1;
        cycle();
        upd = 1'b0;
        chk("pending_after_update", a_pend, 1);
        rem = act.fw * act.fh - k;
        repeat (rem) cycle();
        chk("pending_after_load", a_pend, 0);
        chk("np_720", a_np, 18);
        repeat (2000) cycle();

        // Rejected format: no horizontal blanking.
        bad = c720;
        bad.sw = bad.fw;
        set_cfg(bad);
        repeat (500) cycle();
        upd = 1'b1;
        cycle();
        upd = 1'b0;
        rem = act.fw * act.fh - k;
        repeat (rem) cycle();
        chk("error_after_bad_load", a_err, 1);
        chk("pending_after_bad_load", a_pend, 0);
        repeat (2000) cycle();

        // Randomized small formats with updates mid-frame and on the boundary cycle.
        for (int e = 0; e < 10; e++) begin
            r = rand_cfg(1'b1);
            set_cfg(r);
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            repeat ($urandom_range(0, act.fw * act.fh)) cycle();
            r = rand_cfg($urandom_range(0, 3) != 0);
            set_cfg(r);
            if (e % 2 == 1) begin
                rem = act.fw * act.fh - 1 - k;
                repeat (rem) cycle();
            end
            upd = 1'b1;
            cycle();
            upd = 1'b0;
            repeat (1300) cycle();
        end

        // Reset in the middle of a frame.
        set_cfg(c640);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (2 * 800 + 300) cycle();
        chk("cx_before_reset", a_cx, 300);
        rst = 1'b1;
        cycle();
        chk("reset_cx", a_cx, 0);
        chk("reset_cy", a_cy, 0);
        chk("reset_mode", a_mode, 0);
        chk("reset_hsync", a_hs, 1);
        chk("reset_vsync", a_vs, 1);
        rst = 1'b0;
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_generator.md
Name: hdmi_timing_generator

Overview:
- Runtime-programmable successor to the fixed-format HDMI timing logic.
- Generates pixel position counters, sync pulses with selectable polarity, and the HDMI period classification for every pixel: control, video preamble/guard/data, and data island preamble/guard/period.
- Timing is loaded from configuration inputs into shadow registers and swapped only at frame boundaries, so resolution changes never tear a frame.
- Sits between the pixel clock domain and the TMDS channel encoders and packet assembler.

Parameters:
- BIT_WIDTH, 12, width of horizontal counters and horizontal config fields.
- BIT_HEIGHT, 11, width of vertical counters and vertical config fields.
- MAX_PACKETS, 18, upper bound on data island packets per line (HDMI limit 18).
- DVI_OUTPUT, 0, 1 = suppress all guard, preamble and data island classification.

Ports:
- clk_pixel  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- cfg_frame_width  in  BIT_WIDTH  total pixels per line.
- cfg_frame_height  in  BIT_HEIGHT  total lines per frame.
- cfg_screen_width  in  BIT_WIDTH  active pixels per line.
- cfg_screen_height  in  BIT_HEIGHT  active lines.
- cfg_hsync_start, cfg_hsync_len  in  BIT_WIDTH each  first cx of hsync, and hsync length.
- cfg_vsync_start, cfg_vsync_len  in  BIT_HEIGHT each  first cy of vsync, and vsync length.
- cfg_hsync_pol, cfg_vsync_pol  in  1 each  1 = active-high, 0 = active-low.
- cfg_update  in  1  pulse: request load of cfg_* at next frame boundary.
- cfg_pending  out  1  update requested, not yet applied.
- cfg_error  out  1  last load attempt rejected (sticky).
- cx  out  BIT_WIDTH  current pixel x.
- cy  out  BIT_HEIGHT  current pixel y.
- hsync, vsync  out  1 each  sync outputs at configured polarity.
- mode  out  3  0 control, 1 video data, 2 video guard, 3 data island, 4 data island guard.
- video_preamble, data_island_preamble  out  1 each  preamble flags.
- num_packets  out  5  packets per data island line for the active config.
- frame_start  out  1  one-cycle pulse aligned with classification of (0,0).

Behaviour:
- Derived values from the active (shadow) config:
  - ssx = frame_width - screen_width; ssy = frame_height - screen_height.
  - N = min(MAX_PACKETS, floor((screen_width-2)/32)), or 0 if DVI_OUTPUT.
- Counters:
  - cx increments each cycle and wraps to 0 after frame_width-1.
  - cy increments on each cx wrap and wraps to 0 after frame_height-1.
  - cx/cy are registered; reset forces both to 0.
- Classification is computed from the current (cx,cy) and registered, giving 1-cycle latency relative to cx/cy. Rules, with priority top to bottom:
  - Data island guard: cy<ssy and (cx in [ssx-2,ssx) or cx in [ssx+32N, ssx+32N+2)); requires N>0.
  - Data island: cy<ssy, cx in [ssx, ssx+32N).
  - Video guard: cy>=ssy, cx in [ssx-2, ssx).
  - Video data: cy>=ssy, cx>=ssx.
  - Otherwise control.
- Preambles:
  - video_preamble = cy>=ssy and cx in [ssx-10, ssx-2).
  - data_island_preamble = same cx window with cy<ssy and N>0.
- DVI_OUTPUT=1: mode is only 0 or 1; both preambles are held at 0.
- Sync:
  - hsync is active for cx in [hsync_start, hsync_start+hsync_len).
  - vsync is active for cy in [vsync_start, vsync_start+vsync_len).
  - Output level is active level if pol=1, inverted if pol=0.
  - Sync has the same 1-cycle latency as mode.
- frame_start is registered high for exactly one cycle, the cycle whose outputs describe (0,0).
- Config validity: frame_width>0, frame_height>0, ssx>=10, ssy>=1, 32N+2 <= screen_width (automatically true by the definition of N).
- Shadow load:
  - At reset, cfg_* inputs are loaded unconditionally; cfg_pending=0 and cfg_error=0.
  - cfg_update sets cfg_pending.
  - On the cycle cx=frame_width-1 and cy=frame_height-1 with cfg_pending=1:
    - If the inputs are valid, they load into shadow; cfg_error<=0.
    - Otherwise the shadow is retained and cfg_error<=1.
    - cfg_pending<=0 in both cases.
  - cfg_update asserted on that same boundary cycle loads on that edge.
  - Inputs are sampled only on the load edge.
  - A new config takes effect starting at cx=0, cy=0.
- Reset outputs: cx=0, cy=0, mode=0, both preambles 0, frame_start=0, num_packets derived from the reset config, and hsync/vsync at the inactive level of the reset-loaded polarity.
- Reset mid-frame: everything restarts at (0,0) on the next edge.

Test Plan:
- 640x480 setup (800x525, hsync 16/96 pol 0, vsync 0/2 pol 0), reset released:
  - num_packets=18.
  - At cy=0, the cycle after cx=160 shows mode=4 for cx 158..159, mode=3 for 160..735, mode=4 for 736..737.
  - data_island_preamble covers cx 150..157.
- Same setup at cy=45:
  - video_preamble for cx 150..157, mode=2 for cx 158..159, mode=1 for cx 160..799.
  - hsync low for cx 16..111.
  - vsync low only on cy 0..1.
- frame_start pulses once per 420000 cycles; cx/cy wrap from (799,524) to (0,0).
- Mid-frame, pulse cfg_update with 1280x720 (1650x750) config:
  - cfg_pending=1 until the frame end, old timing continues.
  - Next frame uses ssx=370 and num_packets=18.
- Pulse cfg_update with screen_width=frame_width (ssx=0):
  - At the frame boundary cfg_error=1, cfg_pending=0, old timing is retained.
- DVI_OUTPUT=1: mode never 2/3/4, both preambles always 0, num_packets=0.
- Assert reset at cx=300, cy=200: next cycle cx=0, cy=0, mode=0, syncs inactive.
